// File: rtl/nand_sweep_checker.sv
// rtl/nand_sweep_checker.sv - exhaustive truth-table sweep and check of a combinational gate
//
// Purpose: steps the gate inputs through every value. Each value is held for a
// settle window, and then the gate output is compared against a truth-table
// parameter. The block reports a mismatch count, the first failing vector and
// a pass flag.
//
// Ports:
//   clk            in   clock, all registers update on the rising edge
//   rst_n          in   asynchronous active-low reset
//   start          in   begin a sweep; only looked at while idle
//   dut_out        in   output of the gate under test
//   dut_in         out  registered gate inputs (N_IN bits, msb = in1)
//   busy           out  sweep in progress (start accept until the done cycle)
//   done           out  one-cycle pulse at the end of a sweep
//   pass           out  last sweep had no mismatches (held)
//   err_count      out  mismatches in the current or last sweep (N_IN+1 bits)
//   fail_valid     out  a first failing vector has been captured
//   first_fail_vec out  dut_in value of the first mismatch
module nand_sweep_checker #(
   parameter int                  N_IN       = 2,
   parameter int                  SETTLE_CYC = 4,
   parameter logic [2**N_IN-1:0]  EXPECTED   = 4'b0111
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   input  logic            dut_out,
   output logic [N_IN-1:0] dut_in,
   output logic            busy,
   output logic            done,
   output logic            pass,
   output logic [N_IN:0]   err_count,
   output logic            fail_valid,
   output logic [N_IN-1:0] first_fail_vec
);

   localparam int             CW       = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
   localparam logic [CW-1:0]  CNT_LOAD = CW'(SETTLE_CYC - 1);
   localparam logic [N_IN-1:0] LAST_VEC = {N_IN{1'b1}};

   typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE} state_t;

   state_t        state;
   logic [CW-1:0] cnt;
   logic          exp_bit;
   logic          mismatch;

   // Only meaningful in SAMPLE; dut_in is stable there, so no glitch reaches it.
   assign exp_bit  = EXPECTED[dut_in];
   assign mismatch = (dut_out != exp_bit);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state          <= IDLE;
         cnt            <= '0;
         dut_in         <= '0;
         busy           <= 1'b0;
         done           <= 1'b0;
         pass           <= 1'b0;
         err_count      <= '0;
         fail_valid     <= 1'b0;
         first_fail_vec <= '0;
      end else begin
         case (state)
            IDLE: begin
               done <= 1'b0;
               // Accepting here also covers the done cycle, so a held start
               // chains sweeps back to back.
               if (start) begin
                  dut_in         <= '0;
                  cnt            <= CNT_LOAD;
                  busy           <= 1'b1;
                  pass           <= 1'b0;
                  err_count      <= '0;
                  fail_valid     <= 1'b0;
                  first_fail_vec <= '0;
                  state          <= SETTLE;
               end
            end
            SETTLE: begin
               if (cnt == '0) begin
                  state <= SAMPLE;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            SAMPLE: begin
               if (mismatch) begin
                  err_count <= err_count + (N_IN+1)'(1);
                  if (!fail_valid) begin
                     first_fail_vec <= dut_in;
                     fail_valid     <= 1'b1;
                  end
               end
               if (dut_in != LAST_VEC) begin
                  dut_in <= dut_in + 1'b1;
                  cnt    <= CNT_LOAD;
                  state  <= SETTLE;
               end else begin
                  // err_count has not yet absorbed this cycle's mismatch.
                  done  <= 1'b1;
                  busy  <= 1'b0;
                  pass  <= (err_count == '0) && !mismatch;
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_nand_sweep_checker.sv
// tb/tb_nand_sweep_checker.sv - directed bench for nand_sweep_checker
module tb_nand_sweep_checker;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic       dut_out;
   logic [1:0] dut_in;
   logic       busy, done, pass, fail_valid;
   logic [2:0] err_count;
   logic [1:0] first_fail_vec;

   // 0: NAND gate, 1: output tied 1, 2: output tied 0
   logic [1:0] mode = 2'd0;

   int errors = 0;
   int checks = 0;

   // Results recorded by run_sweep
   int done_edge;
   int done_pulses;
   int seq_bad;

   always #5 clk = ~clk;

   assign dut_out = (mode == 2'd0) ? ~(&dut_in) : ((mode == 2'd1) ? 1'b1 : 1'b0);

   nand_sweep_checker #(.N_IN(2), .SETTLE_CYC(4), .EXPECTED(4'b0111)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .dut_out(dut_out),
      .dut_in(dut_in), .busy(busy), .done(done), .pass(pass),
      .err_count(err_count), .fail_valid(fail_valid), .first_fail_vec(first_fail_vec)
   );

   // Pulse start (accepted at edge 0), then observe 25 edges. Optionally
   // re-pulse start so it is sampled at edges 3 and 12.
   task automatic run_sweep(input bit repulse);
      int exp_vec;
      done_edge   = -1;
      done_pulses = 0;
      seq_bad     = 0;
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      for (int k = 1; k <= 25; k++) begin
         @(posedge clk);
         #1;
         start = repulse && (k == 2 || k == 11);
         if (done) begin
            done_pulses++;
            if (done_edge < 0) done_edge = k;
         end
         if (k <= 20) begin
            exp_vec = (k >= 20) ? 3 : k / 5;
            if (dut_in !== 2'(exp_vec)) seq_bad++;
            if (busy !== (k < 20)) seq_bad++;
         end
      end
      start = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      #1;
      checks++;
      if ({dut_in, busy, done, pass, err_count, fail_valid, first_fail_vec} !== 11'd0) begin
         errors++;
         $display("FAIL reset_outputs: got %b expected 0",
                  {dut_in, busy, done, pass, err_count, fail_valid, first_fail_vec});
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic check_clean(input string tag);
      checks++;
      if (done_edge !== 20) begin
         errors++; $display("FAIL %s_done_edge: got %0d expected 20", tag, done_edge);
      end
      checks++;
      if (done_pulses !== 1) begin
         errors++; $display("FAIL %s_done_pulses: got %0d expected 1", tag, done_pulses);
      end
      checks++;
      if (seq_bad !== 0) begin
         errors++; $display("FAIL %s_sequence: got %0d bad samples expected 0", tag, seq_bad);
      end
      checks++;
      if ({pass, err_count, fail_valid} !== {1'b1, 3'd0, 1'b0}) begin
         errors++;
         $display("FAIL %s_result: got pass=%b err=%0d fv=%b expected pass=1 err=0 fv=0",
                  tag, pass, err_count, fail_valid);
      end
   endtask

   task automatic test_nand();
      mode = 2'd0;
      run_sweep(1'b0);
      check_clean("nand");
   endtask

   task automatic test_tied_high();
      mode = 2'd1;
      run_sweep(1'b0);
      checks++;
      if ({pass, err_count, fail_valid, first_fail_vec} !== {1'b0, 3'd1, 1'b1, 2'b11}) begin
         errors++;
         $display("FAIL tied1_result: got pass=%b err=%0d fv=%b ffv=%b expected 0 1 1 11",
                  pass, err_count, fail_valid, first_fail_vec);
      end
      checks++;
      if (done_edge !== 20) begin
         errors++; $display("FAIL tied1_done_edge: got %0d expected 20", done_edge);
      end
   endtask

   task automatic test_tied_low();
      mode = 2'd2;
      run_sweep(1'b0);
      checks++;
      if ({pass, err_count, fail_valid, first_fail_vec} !== {1'b0, 3'd3, 1'b1, 2'b00}) begin
         errors++;
         $display("FAIL tied0_result: got pass=%b err=%0d fv=%b ffv=%b expected 0 3 1 00",
                  pass, err_count, fail_valid, first_fail_vec);
      end
   endtask

   task automatic test_start_while_busy();
      mode = 2'd0;
      run_sweep(1'b1);
      check_clean("busy_start");
   endtask

   task automatic test_reset_mid_sweep();
      int seen_done;
      mode = 2'd0;
      seen_done = 0;
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (6) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      checks++;
      if ({dut_in, busy, done, pass, err_count, fail_valid, first_fail_vec} !== 11'd0) begin
         errors++;
         $display("FAIL midreset_outputs: got %b expected 0",
                  {dut_in, busy, done, pass, err_count, fail_valid, first_fail_vec});
      end
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (20) begin
         @(posedge clk);
         #1;
         if (done || busy) seen_done++;
      end
      checks++;
      if (seen_done !== 0) begin
         errors++; $display("FAIL midreset_quiet: got %0d active cycles expected 0", seen_done);
      end
      run_sweep(1'b0);
      check_clean("after_reset");
   endtask

   task automatic test_back_to_back();
      int first_done, second_done, pulses;
      first_done = -1; second_done = -1; pulses = 0;
      mode = 2'd2;
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      for (int k = 1; k <= 42; k++) begin
         @(posedge clk);
         #1;
         if (done) begin
            pulses++;
            if (first_done < 0) first_done = k; else second_done = k;
         end
         if (k == 20) begin
            checks++;
            if ({done, err_count, pass} !== {1'b1, 3'd3, 1'b0}) begin
               errors++;
               $display("FAIL b2b_first: got done=%b err=%0d pass=%b expected 1 3 0",
                        done, err_count, pass);
            end
            mode = 2'd0;
         end
         if (k == 21) begin
            checks++;
            if ({busy, err_count, pass, fail_valid} !== {1'b1, 3'd0, 1'b0, 1'b0}) begin
               errors++;
               $display("FAIL b2b_reaccept: got busy=%b err=%0d pass=%b fv=%b expected 1 0 0 0",
                        busy, err_count, pass, fail_valid);
            end
         end
         if (k == 41) begin
            checks++;
            if ({done, err_count, pass} !== {1'b1, 3'd0, 1'b1}) begin
               errors++;
               $display("FAIL b2b_second: got done=%b err=%0d pass=%b expected 1 0 1",
                        done, err_count, pass);
            end
            start = 1'b0;
         end
         if (k == 42) begin
            checks++;
            if ({busy, done} !== 2'b00) begin
               errors++;
               $display("FAIL b2b_stop: got busy=%b done=%b expected 0 0", busy, done);
            end
         end
      end
      checks++;
      if ({first_done, second_done, pulses} !== {32'sd20, 32'sd41, 32'sd2}) begin
         errors++;
         $display("FAIL b2b_done_edges: got %0d,%0d (%0d pulses) expected 20,41 (2)",
                  first_done, second_done, pulses);
      end
   endtask

   initial begin
      test_reset();
      test_nand();
      test_tied_high();
      test_tied_low();
      test_start_while_busy();
      test_reset_mid_sweep();
      test_back_to_back();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
